// File: rtl/piccolo_rp_iter.sv
// piccolo_rp_iter: iterative Piccolo round-permutation engine.
// Captures a 64-bit state word and applies RP (or RP^-1) once per clock,
// in_iter times, then holds the result until the consumer accepts it.
// Optional feature macro: PICCOLO_RP_INV_EN. When it is defined, in_inv
// selects the inverse permutation. When it is not defined, RP is always
// applied forward and in_inv is ignored.
module piccolo_rp_iter #(
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic [ITER_W-1:0] in_iter,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Forward RP: (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5), where x0 is the top byte.
    function automatic logic [63:0] rp_fwd(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48],
                x[15:8],  x[39:32], x[63:56], x[23:16]};
    endfunction

`ifdef PICCOLO_RP_INV_EN
    // Inverse RP: (y0..y7) -> (y6,y3,y0,y5,y2,y7,y4,y1).
    function automatic logic [63:0] rp_inv(input logic [63:0] y);
        return {y[15:8],  y[39:32], y[63:56], y[23:16],
                y[47:40], y[7:0],   y[31:24], y[55:48]};
    endfunction
`endif

    state_e              fsm_q, fsm_d;
    logic [63:0]         data_q, data_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

`ifdef PICCOLO_RP_INV_EN
    logic                inv_q, inv_d;
`else
    // The port stays for interface stability. Without the inverse logic it has no load.
    logic                unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Next-state logic: FSM transitions, datapath update and registered flag values.
    always_comb begin
        // NOTE: every signal gets a hold value first, so no path through the
        // case/if tree can leave one unassigned and infer a latch.
        fsm_d  = fsm_q;
        data_d = data_q;
        cnt_d  = cnt_q;
`ifdef PICCOLO_RP_INV_EN
        inv_d  = inv_q;
`endif

        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    cnt_d  = in_iter;
`ifdef PICCOLO_RP_INV_EN
                    inv_d  = in_inv;
`endif
                    fsm_d  = (in_iter == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
`ifdef PICCOLO_RP_INV_EN
                data_d = inv_q ? rp_inv(data_q) : rp_fwd(data_q);
`else
                data_d = rp_fwd(data_q);
`endif
                cnt_d  = cnt_q - ITER_W'(1);
                if (cnt_q == ITER_W'(1)) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // An abort overrides every transition. The state word is kept, but
        // nothing from this cycle is captured.
        if (clr) begin
            fsm_d  = S_IDLE;
            cnt_d  = '0;
            data_d = data_q;
`ifdef PICCOLO_RP_INV_EN
            inv_d  = inv_q;
`endif
        end

        // The handshake flags are decoded from the next state so that they
        // come straight from flops.
        in_ready_d  = (fsm_d == S_IDLE);
        out_valid_d = (fsm_d == S_DONE);
        busy_d      = (fsm_d != S_IDLE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PICCOLO_RP_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values, whatever order these statements are in.
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef PICCOLO_RP_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_piccolo_rp_iter.sv
// Testbench for piccolo_rp_iter. The driver pushes expected results into a
// scoreboard queue, and an independent monitor pops and compares them at
// each output handshake. Random traffic is checked against a byte-array
// model of RP. The model obtains RP^-1 as RP^3, because RP^4 is the identity.
module tb_piccolo_rp_iter;

    localparam int ITER_W = 4;

    typedef struct {
        logic [63:0] data;
        int          n;
        int          acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_data = '0;
    logic [ITER_W-1:0] in_iter = '0;
    logic              in_inv = 1'b0;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic              busy;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic rand_ready = 1'b0;
    logic hold_ready = 1'b1;
    int   fp[8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    piccolo_rp_iter #(.ITER_W(ITER_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_iter   (in_iter),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: drives out_ready either randomly or at a fixed level.
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: byte permutation table applied n times (3n times for inverse).
    function automatic logic [63:0] model(input logic [63:0] d, input int n, input logic inv);
        logic [7:0] b[8];
        logic [7:0] t[8];
        logic [63:0] r;
        int reps;
        reps = n;
`ifdef PICCOLO_RP_INV_EN
        if (inv) reps = 3 * n;
`endif
        for (int i = 0; i < 8; i++) b[i] = d[63 - 8*i -: 8];
        repeat (reps) begin
            for (int i = 0; i < 8; i++) t[i] = b[fp[i]];
            b = t;
        end
        for (int i = 0; i < 8; i++) r[63 - 8*i -: 8] = b[i];
        return r;
    endfunction

    // Producer: offers one word, waits for acceptance, and records the expected result.
    task automatic send(input logic [63:0] d, input int n, input logic inv, input logic [63:0] exp);
        int w;
        w = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_iter  = ITER_W'(n);
        in_inv   = inv;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{data: exp, n: n, acc: cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: checks latency on each rising out_valid, holding stability under
    // backpressure, and result data at each handshake.
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_valid", {63'd0, out_valid}, 64'd0);
                else check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].n));
            end
            if (out_valid && prev_valid && !prev_hs) check("hold_stable", out_data, prev_data);
            if (out_valid && out_ready && sb.size() != 0) begin
                check("out_data", out_data, sb[0].data);
                void'(sb.pop_front());
            end
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        int          n;
        logic        v;

        // Reset state.
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_data", out_data, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors.
        send(64'h1122334455667788, 1, 1'b0, 64'h3388552277441166);
        send(64'h8877665544332211, 1, 1'b0, 64'h6611447722558833);
        send(64'h1234567890abcdef, 1, 1'b0, 64'h56ef9034cd7812ab);
        send(64'h1122334455667788, 2, 1'b0, 64'h5566778811223344);
        send(64'h1122334455667788, 4, 1'b0, 64'h1122334455667788);
        send(64'h1122334455667788, 0, 1'b0, 64'h1122334455667788);
`ifdef PICCOLO_RP_INV_EN
        send(64'h1122334455667788, 1, 1'b1, 64'h7744116633885522);
`else
        send(64'h1122334455667788, 1, 1'b1, 64'h3388552277441166);
`endif
        drain();

        // Backpressure: the result is held for 10 cycles, and new offers are ignored.
        hold_ready = 1'b0;
        send(64'hdeadbeefcafef00d, 3, 1'b0, model(64'hdeadbeefcafef00d, 3, 1'b0));
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = i[0];
            in_data  = $urandom();
            in_iter  = 4'd0;
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_data", out_data, model(64'hdeadbeefcafef00d, 3, 1'b0));
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        hold_ready = 1'b1;
        drain();
        check("bp_no_extra", {63'd0, out_valid}, 64'd0);

        // Abort in mid-RUN: return to idle with no output.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 64'h0123456789abcdef; in_iter = 4'd15; in_inv = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_in_ready", {63'd0, in_ready}, 64'd1);
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (20) @(posedge clk);
        send(64'h1122334455667788, 1, 1'b0, 64'h3388552277441166);
        drain();

        // Abort in the accept cycle: the offer is not captured.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 64'h5555aaaa5555aaaa; in_iter = 4'd2; clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        check("clr_acc_in_ready", {63'd0, in_ready}, 64'd1);
        check("clr_acc_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(posedge clk);

        // Asynchronous reset in mid-RUN.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 64'hfedcba9876543210; in_iter = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_out_data", out_data, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Random traffic under random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            d = {$urandom(), $urandom()};
            n = $urandom_range(0, 15);
            v = 1'($urandom_range(0, 1));
            send(d, n, v, model(d, n, v));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_ready = 1'b0;
        hold_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
